// File: rtl/byte_fifo.sv
// Single-clock byte FIFO with registered read data, a one-cycle read strobe and
// occupancy status decoded from a registered counter.
module byte_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr,
   input  logic [WIDTH-1:0]           datin,
   input  logic                       rd,
   output logic [WIDTH-1:0]           datout,
   output logic                       dato,
   output logic                       full,
   output logic                       empy,
   output logic [$clog2(DEPTH):0]     level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];

   logic [AW-1:0]    wptr_q, wptr_d;
   logic [AW-1:0]    rptr_q, rptr_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0] datout_q, datout_d;
   logic             dato_q, dato_d;

   logic             wa;
   logic             ra;

   // Status comes only from the registered count, never from wr/rd.
   assign full  = (cnt_q == FULL_CNT);
   assign empy  = (cnt_q == '0);
   assign level = cnt_q;

   // A write while full is still accepted when a read frees a slot the same cycle.
   assign ra = rd & ~empy;
   assign wa = wr & (~full | ra);

   always_comb begin
      wptr_d   = wptr_q;
      rptr_d   = rptr_q;
      cnt_d    = cnt_q;
      datout_d = datout_q;
      dato_d   = 1'b0;

      if (wa) begin
         wptr_d = wptr_q + 1'b1;
      end

      if (ra) begin
         rptr_d   = rptr_q + 1'b1;
         datout_d = mem[rptr_q];
         dato_d   = 1'b1;
      end

      if (wa && !ra) begin
         cnt_d = cnt_q + 1'b1;
      end else if (ra && !wa) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         cnt_q    <= '0;
         datout_q <= '0;
         dato_q   <= 1'b0;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         cnt_q    <= cnt_d;
         datout_q <= datout_d;
         dato_q   <= dato_d;
      end
   end

   // Storage is not reset; stale contents are unreachable once the pointers clear.
   always_ff @(posedge clk) begin
      if (wa) begin
         mem[wptr_q] <= datin;
      end
   end

   assign datout = datout_q;
   assign dato   = dato_q;

endmodule

// File: tb/tb_byte_fifo.sv
// Directed bench for byte_fifo: ordering, fill/overflow, underflow,
// simultaneous access, pointer wrap and asynchronous reset.
module tb_byte_fifo;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr;
   logic [7:0] datin;
   logic       rd;
   logic [7:0] datout;
   logic       dato;
   logic       full;
   logic       empy;
   logic [4:0] level;

   int vectors = 0;
   int miscompares = 0;

   byte_fifo #(.WIDTH(8), .DEPTH(16)) dut (
      .clk    (clk),
      .rst    (rst),
      .wr     (wr),
      .datin  (datin),
      .rd     (rd),
      .datout (datout),
      .dato   (dato),
      .full   (full),
      .empy   (empy),
      .level  (level)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [7:0] d;
      logic [7:0] dprev;

      rst = 1'b0; wr = 1'b0; rd = 1'b0; datin = 8'h00;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      check("rst_empy",   32'(empy),   32'd1);
      check("rst_full",   32'(full),   32'd0);
      check("rst_level",  32'(level),  32'd0);
      check("rst_dato",   32'(dato),   32'd0);
      check("rst_datout", 32'(datout), 32'h00);

      // Ordering
      wr = 1'b1; datin = 8'hA0; tick();
      check("ord_level1", 32'(level), 32'd1);
      check("ord_empy0",  32'(empy),  32'd0);
      datin = 8'h11; tick();
      datin = 8'h5A; tick();
      wr = 1'b0; rd = 1'b1; tick();
      check("ord_rd0", 32'(datout), 32'hA0);
      check("ord_v0",  32'(dato),   32'd1);
      tick();
      check("ord_rd1", 32'(datout), 32'h11);
      check("ord_v1",  32'(dato),   32'd1);
      tick();
      check("ord_rd2", 32'(datout), 32'h5A);
      check("ord_v2",  32'(dato),   32'd1);
      rd = 1'b0; tick();
      check("ord_vend",  32'(dato),   32'd0);
      check("ord_empy",  32'(empy),   32'd1);
      check("ord_hold",  32'(datout), 32'h5A);

      // Fill and overflow
      wr = 1'b1;
      for (int i = 0; i < 16; i++) begin
         datin = 8'(i); tick();
      end
      check("fill_full",  32'(full),  32'd1);
      check("fill_level", 32'(level), 32'd16);
      datin = 8'hFF; tick();
      check("ovf_full",  32'(full),  32'd1);
      check("ovf_level", 32'(level), 32'd16);
      wr = 1'b0; rd = 1'b1;
      for (int i = 0; i < 16; i++) begin
         tick();
         check("drain_data", 32'(datout), 32'(i));
      end
      rd = 1'b0; tick();
      check("drain_empy", 32'(empy),  32'd1);
      check("drain_full", 32'(full),  32'd0);
      check("drain_dato", 32'(dato),  32'd0);

      // Underflow
      rd = 1'b1; tick();
      check("udf_dato",   32'(dato),   32'd0);
      check("udf_datout", 32'(datout), 32'h0F);
      check("udf_level",  32'(level),  32'd0);
      rd = 1'b0; wr = 1'b1; datin = 8'h3C; tick();
      wr = 1'b0; rd = 1'b1; tick();
      check("udf_rd",   32'(datout), 32'h3C);
      check("udf_v",    32'(dato),   32'd1);
      rd = 1'b0; tick();

      // Simultaneous access when full
      wr = 1'b1;
      for (int i = 0; i < 16; i++) begin
         datin = 8'(8'h80 + i); tick();
      end
      check("sf_full", 32'(full), 32'd1);
      datin = 8'h77; rd = 1'b1; tick();
      check("sf_datout", 32'(datout), 32'h80);
      check("sf_level",  32'(level),  32'd16);
      check("sf_dato",   32'(dato),   32'd1);
      wr = 1'b0;
      for (int i = 1; i < 16; i++) begin
         tick();
         check("sf_drain", 32'(datout), 32'(8'h80 + i));
      end
      tick();
      check("sf_last", 32'(datout), 32'h77);
      check("sf_empy", 32'(empy),   32'd1);

      // Simultaneous access when empty: no fall-through
      wr = 1'b1; datin = 8'h42; rd = 1'b1; tick();
      check("se_dato",   32'(dato),   32'd0);
      check("se_level",  32'(level),  32'd1);
      check("se_datout", 32'(datout), 32'h77);
      wr = 1'b0; tick();
      check("se_rd", 32'(datout), 32'h42);
      check("se_v",  32'(dato),   32'd1);
      rd = 1'b0; tick();

      // Wrap-around: streaming write+read pairs
      d = 8'h01;
      wr = 1'b1; datin = d; tick();
      for (int i = 1; i < 40; i++) begin
         dprev = d;
         d = 8'(i * 3 + 1);
         datin = d; rd = 1'b1; tick();
         check("wrap_data", 32'(datout), 32'(dprev));
         check("wrap_lvl",  32'(level),  32'd1);
      end
      wr = 1'b0; tick();
      check("wrap_last",  32'(datout), 32'(d));
      check("wrap_empty", 32'(level),  32'd0);
      rd = 1'b0; tick();

      // Asynchronous reset mid-traffic
      wr = 1'b1; datin = 8'hAA; tick();
      datin = 8'hBB; tick();
      wr = 1'b0; rd = 1'b1; tick();
      check("mr_pre_dato", 32'(dato), 32'd1);
      rd = 1'b0; wr = 1'b1; datin = 8'hCC;
      #2 rst = 1'b0;
      #1;
      check("mr_empy",   32'(empy),   32'd1);
      check("mr_full",   32'(full),   32'd0);
      check("mr_level",  32'(level),  32'd0);
      check("mr_dato",   32'(dato),   32'd0);
      check("mr_datout", 32'(datout), 32'h00);
      wr = 1'b0;
      @(negedge clk);
      rst = 1'b1; wr = 1'b1; datin = 8'h55;
      tick();
      check("mr_level1", 32'(level), 32'd1);
      wr = 1'b0; rd = 1'b1; tick();
      check("mr_rd", 32'(datout), 32'h55);
      rd = 1'b0; tick();
      check("mr_final_empy", 32'(empy), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
